// File: rtl/axi_sram_slave_pkg.sv
// Shared AXI3 constants, FSM encodings and burst address helpers for the SRAM slave.
// Pure declarations: no latency, no flow control.
package axi_sram_slave_pkg;

  localparam int ID_W   = 4;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {R_IDLE, R_DATA} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;

  // WRAP is treated as unsupported, so its address simply advances like INCR.
  function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                            input logic [2:0]  size,
                                            input logic [1:0]  burst);
    return (burst == BURST_FIXED) ? addr : addr + (32'd1 << size);
  endfunction

  function automatic logic burst_err(input logic [1:0] burst);
    return (burst == BURST_WRAP) || (burst == 2'b11);
  endfunction

endpackage

// File: rtl/axi_sram_slave_ram.sv
// Simple dual-port word RAM, byte-enabled write, read-first on address collision.
// Read data one cycle after ren; output register holds while ren=0.
module axi_sram_slave_ram
  import axi_sram_slave_pkg::*;
#(
  parameter int    ADDR_WIDTH = 12,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  ren,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_W-1:0]     rdata,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [STRB_W-1:0]     wbe,
  input  logic [DATA_W-1:0]     wdata
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (ren) rdata <= mem[raddr];
    if (wen) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wbe[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 slave over on-chip SRAM; independent read/write FSMs, one outstanding burst each.
// First read beat 1 cycle after AR; beats stream back-to-back, rready/bready stalls hold payload.
module axi_sram_slave
  import axi_sram_slave_pkg::*;
#(
  parameter int    ADDR_WIDTH = 12,
  parameter string INIT_FILE  = ""
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [ID_W-1:0]   arid,
  input  logic [31:0]       araddr,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic [1:0]        arlock,
  input  logic [3:0]        arcache,
  input  logic [2:0]        arprot,
  input  logic              arvalid,
  output logic              arready,
  output logic [ID_W-1:0]   rid,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  input  logic [ID_W-1:0]   awid,
  input  logic [31:0]       awaddr,
  input  logic [7:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic [1:0]        awlock,
  input  logic [3:0]        awcache,
  input  logic [2:0]        awprot,
  input  logic              awvalid,
  output logic              awready,
  input  logic [ID_W-1:0]   wid,
  input  logic [DATA_W-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  output logic [ID_W-1:0]   bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready
);

  rd_state_e             r_state, r_next;
  logic [ID_W-1:0]       r_id;
  logic [7:0]            r_len, r_cnt;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic [31:0]           r_addr, r_addr_nxt;
  logic                  r_err, ar_hs, r_adv;

  wr_state_e             w_state, w_next;
  logic [ID_W-1:0]       w_id;
  logic [7:0]            w_len, w_cnt;
  logic [2:0]            w_size;
  logic [1:0]            w_burst, b_resp;
  logic [31:0]           w_addr, w_addr_nxt;
  logic                  w_err, aw_hs, w_adv;

  logic                  ram_ren, ram_wen;
  logic [ADDR_WIDTH-1:0] ram_raddr;
  logic [DATA_W-1:0]     ram_rdata;
  logic                  unused_ok;

  assign ar_hs      = arvalid && arready;
  assign r_addr_nxt = next_addr(r_addr, r_size, r_burst);
  assign rvalid     = (r_state == R_DATA);
  assign rlast      = rvalid && (r_cnt == r_len);
  assign rid        = r_id;
  assign rresp      = r_err ? RESP_SLVERR : RESP_OKAY;
  assign rdata      = r_err ? '0 : ram_rdata;

  // RAM is only read on the AR handshake or an accepted non-last beat, so stalls freeze rdata.
  always_comb begin
    r_next    = r_state;
    ram_ren   = 1'b0;
    ram_raddr = r_addr_nxt[ADDR_WIDTH+1:2];
    r_adv     = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (ar_hs) begin
          r_next    = R_DATA;
          ram_ren   = 1'b1;
          ram_raddr = araddr[ADDR_WIDTH+1:2];
        end
      end
      R_DATA: begin
        if (rready) begin
          if (rlast) begin
            r_next = R_IDLE;
          end else begin
            r_adv   = 1'b1;
            ram_ren = 1'b1;
          end
        end
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state <= R_IDLE;
      arready <= 1'b0;
      r_id    <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_addr  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= r_next;
      arready <= (r_next == R_IDLE);
      if (ar_hs) begin
        r_id    <= arid;
        r_len   <= arlen;
        r_size  <= arsize;
        r_burst <= arburst;
        r_addr  <= araddr;
        r_cnt   <= '0;
        r_err   <= burst_err(arburst);
      end else if (r_adv) begin
        r_addr <= r_addr_nxt;
        r_cnt  <= r_cnt + 8'd1;
      end
    end
  end

  assign aw_hs      = awvalid && awready;
  assign w_addr_nxt = next_addr(w_addr, w_size, w_burst);
  assign wready     = (w_state == W_DATA);
  assign bvalid     = (w_state == W_RESP);
  assign bid        = w_id;
  assign bresp      = b_resp;

  always_comb begin
    w_next  = w_state;
    ram_wen = 1'b0;
    w_adv   = 1'b0;
    case (w_state)
      W_IDLE: if (aw_hs) w_next = W_DATA;
      W_DATA: begin
        if (wvalid) begin
          w_adv   = 1'b1;
          ram_wen = !w_err;
          if (wlast) w_next = W_RESP;
        end
      end
      W_RESP: if (bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      w_state <= W_IDLE;
      awready <= 1'b0;
      w_id    <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_addr  <= '0;
      w_err   <= 1'b0;
      b_resp  <= RESP_OKAY;
    end else begin
      w_state <= w_next;
      awready <= (w_next == W_IDLE);
      if (aw_hs) begin
        w_id    <= awid;
        w_len   <= awlen;
        w_size  <= awsize;
        w_burst <= awburst;
        w_addr  <= awaddr;
        w_cnt   <= '0;
        w_err   <= burst_err(awburst);
      end else if (w_adv) begin
        w_addr <= w_addr_nxt;
        w_cnt  <= w_cnt + 8'd1;
        // An early wlast leaves count short of awlen and is reported as a slave error.
        if (wlast) b_resp <= (w_err || (w_cnt != w_len)) ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  axi_sram_slave_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INIT_FILE  (INIT_FILE)
  ) u_ram (
    .clk   (aclk),
    .ren   (ram_ren),
    .raddr (ram_raddr),
    .rdata (ram_rdata),
    .wen   (ram_wen),
    .waddr (w_addr[ADDR_WIDTH+1:2]),
    .wbe   (wstrb),
    .wdata (wdata)
  );

  assign unused_ok = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid,
                       r_addr_nxt[31:ADDR_WIDTH+2], r_addr_nxt[1:0],
                       w_addr_nxt[31:ADDR_WIDTH+2], w_addr_nxt[1:0]};

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: stimulus pushes expected R/B responses, a negedge monitor pops and checks.
module tb_axi_sram_slave;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [3:0]  arid, awid, rid, bid;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;

  always #5 aclk = ~aclk;

  axi_sram_slave dut (
    .aclk(aclk), .aresetn(aresetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(2'b00), .arcache(4'h0), .arprot(3'b000), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(2'b00), .awcache(4'h0), .awprot(3'b000), .awvalid(awvalid), .awready(awready),
    .wid(4'h0), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  typedef struct packed {logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last;} rbeat_t;
  typedef struct packed {logic [3:0] id; logic [1:0] resp;} bbeat_t;

  rbeat_t exp_r[$];
  bbeat_t exp_b[$];
  int     n_tests = 0;
  int     n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard pop on each handshake, plus payload stability across stalls.
  logic   r_stall = 1'b0, b_stall = 1'b0;
  rbeat_t r_held;
  bbeat_t b_held;
  always @(negedge aclk) begin
    rbeat_t r_now;
    bbeat_t b_now;
    r_now = '{id: rid, data: rdata, resp: rresp, last: rlast};
    b_now = '{id: bid, resp: bresp};
    if (rvalid && rready) begin
      if (exp_r.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL r_unexpected: got beat 0x%0h, expected no beat", r_now);
      end else chk("r_beat", r_now, exp_r.pop_front());
    end
    if (r_stall && rvalid) chk("r_stable", r_now, r_held);
    r_stall = rvalid && !rready;
    r_held  = r_now;
    if (bvalid && bready) begin
      if (exp_b.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL b_unexpected: got resp 0x%0h, expected no resp", b_now);
      end else chk("b_resp", b_now, exp_b.pop_front());
    end
    if (b_stall && bvalid) chk("b_stable", b_now, b_held);
    b_stall = bvalid && !bready;
    b_held  = b_now;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic ar_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst);
    logic got;
    got = 1'b0;
    arid = id; araddr = addr; arlen = len; arsize = 3'd2; arburst = burst; arvalid = 1'b1;
    for (int k = 0; k < 64 && !got; k++) begin
      @(negedge aclk);
      got = arready;
    end
    chk("ar_handshake", got, 1);
    @(posedge aclk); #1;
    arvalid = 1'b0;
  endtask

  task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst);
    logic got;
    got = 1'b0;
    awid = id; awaddr = addr; awlen = len; awsize = 3'd2; awburst = burst; awvalid = 1'b1;
    for (int k = 0; k < 64 && !got; k++) begin
      @(negedge aclk);
      got = awready;
    end
    chk("aw_handshake", got, 1);
    @(posedge aclk); #1;
    awvalid = 1'b0;
  endtask

  task automatic w_send(input logic [31:0] data, input logic [3:0] strb, input logic last);
    logic got;
    got = 1'b0;
    wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
    for (int k = 0; k < 64 && !got; k++) begin
      @(negedge aclk);
      got = wready;
    end
    chk("w_handshake", got, 1);
    @(posedge aclk); #1;
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 100 && (exp_r.size() != 0 || exp_b.size() != 0); k++) tick(1);
    chk(name, exp_r.size() + exp_b.size(), 0);
    exp_r.delete();
    exp_b.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [6:0] pat;
    int         seen;
    aresetn = 1'b0;
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0; rready = 1'b1; bready = 1'b1;
    arid = '0; araddr = '0; arlen = '0; arsize = 3'd2; arburst = 2'b01;
    awid = '0; awaddr = '0; awlen = '0; awsize = 3'd2; awburst = 2'b01;
    wdata = '0; wstrb = '0; wlast = 1'b0;
    dut.u_ram.mem[16] = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) dut.u_ram.mem[i] = 32'(i + 1);
    dut.u_ram.mem[32] = 32'hCAFEF00D;
    dut.u_ram.mem[80] = 32'h55555555;
    for (int i = 0; i < 8; i++) dut.u_ram.mem[48 + i] = 32'h300 + 32'(i);

    // Reset state
    tick(3);
    chk("rst_arready", arready, 0); chk("rst_awready", awready, 0);
    chk("rst_rvalid", rvalid, 0);   chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);   chk("rst_rlast", rlast, 0);
    chk("rst_rid", rid, 0);         chk("rst_bid", bid, 0);
    chk("rst_rresp", rresp, 0);     chk("rst_bresp", bresp, 0);
    aresetn = 1'b1;
    chk("rel_arready_pre", arready, 0);
    tick(1);
    chk("rel_arready", arready, 1); chk("rel_awready", awready, 1);

    // Single read, 1-cycle latency, one idle cycle before next AR
    exp_r.push_back('{id: 4'd3, data: 32'hDEADBEEF, resp: 2'b00, last: 1'b1});
    ar_send(4'd3, 32'h40, 8'd0, 2'b01);
    chk("rd1_rvalid", rvalid, 1); chk("rd1_rlast", rlast, 1); chk("rd1_arready_busy", arready, 0);
    tick(1);
    chk("rd1_rvalid_done", rvalid, 0); chk("rd1_arready_back", arready, 1);
    drain("rd1_drain");

    // Burst read with rready pattern 1,0,0,1,1,0,1
    for (int i = 0; i < 4; i++)
      exp_r.push_back('{id: 4'd1, data: 32'(i + 1), resp: 2'b00, last: (i == 3)});
    ar_send(4'd1, 32'h0, 8'd3, 2'b01);
    pat = 7'b1011001;
    for (int i = 0; i < 7; i++) begin
      rready = pat[i];
      tick(1);
    end
    rready = 1'b1;
    chk("burst_rvalid_end", rvalid, 0);
    drain("burst_drain");

    // Strobed write then read back
    dut.u_ram.mem[2] = 32'h11223344;
    chk("w_idle_wready", wready, 0);
    exp_b.push_back('{id: 4'd5, resp: 2'b00});
    aw_send(4'd5, 32'h8, 8'd0, 2'b01);
    w_send(32'hAABBCCDD, 4'b0101, 1'b1);
    drain("strb_b_drain");
    exp_r.push_back('{id: 4'd5, data: 32'h11BB33DD, resp: 2'b00, last: 1'b1});
    ar_send(4'd5, 32'h8, 8'd0, 2'b01);
    drain("strb_r_drain");

    // Short burst: wlast on beat 2 of 4, response held under bready=0
    bready = 1'b0;
    aw_send(4'd6, 32'h100, 8'd3, 2'b01);
    w_send(32'h1, 4'hF, 1'b0);
    w_send(32'h2, 4'hF, 1'b1);
    chk("short_wready", wready, 0); chk("short_bvalid", bvalid, 1);
    chk("short_bid", bid, 6);       chk("short_bresp", bresp, 2);
    repeat (3) begin
      tick(1);
      chk("short_bvalid_hold", bvalid, 1);
    end
    exp_b.push_back('{id: 4'd6, resp: 2'b10});
    bready = 1'b1;
    drain("short_drain");
    exp_b.push_back('{id: 4'd7, resp: 2'b00});
    aw_send(4'd7, 32'h104, 8'd0, 2'b01);
    w_send(32'h0BADF00D, 4'hF, 1'b1);
    drain("after_short_drain");
    exp_r.push_back('{id: 4'd4, data: 32'h0BADF00D, resp: 2'b00, last: 1'b1});
    ar_send(4'd4, 32'h104, 8'd0, 2'b01);
    drain("after_short_rd");

    // WRAP read: two error beats with zero data
    exp_r.push_back('{id: 4'd2, data: 32'h0, resp: 2'b10, last: 1'b0});
    exp_r.push_back('{id: 4'd2, data: 32'h0, resp: 2'b10, last: 1'b1});
    ar_send(4'd2, 32'h0, 8'd1, 2'b10);
    drain("wrap_drain");

    // Reserved-burst write: error response, memory untouched
    exp_b.push_back('{id: 4'd11, resp: 2'b10});
    aw_send(4'd11, 32'h140, 8'd0, 2'b11);
    w_send(32'hFFFFFFFF, 4'hF, 1'b1);
    drain("rsvd_w_drain");
    exp_r.push_back('{id: 4'd11, data: 32'h55555555, resp: 2'b00, last: 1'b1});
    ar_send(4'd11, 32'h140, 8'd0, 2'b01);
    drain("rsvd_r_drain");

    // Same-cycle write and read of word 0x20: read-first
    exp_b.push_back('{id: 4'd8, resp: 2'b00});
    exp_r.push_back('{id: 4'hA, data: 32'hCAFEF00D, resp: 2'b00, last: 1'b1});
    aw_send(4'd8, 32'h80, 8'd0, 2'b01);
    fork
      ar_send(4'hA, 32'h80, 8'd0, 2'b01);
      w_send(32'h12345678, 4'hF, 1'b1);
    join
    drain("coll_drain");
    exp_r.push_back('{id: 4'hA, data: 32'h12345678, resp: 2'b00, last: 1'b1});
    ar_send(4'hA, 32'h80, 8'd0, 2'b01);
    drain("coll_new_drain");

    // Reset during beat 2 of an 8-beat read
    exp_r.push_back('{id: 4'd9, data: 32'h300, resp: 2'b00, last: 1'b0});
    ar_send(4'd9, 32'hC0, 8'd7, 2'b01);
    tick(1);
    rready  = 1'b0;
    aresetn = 1'b0;
    tick(1);
    chk("mid_rst_rvalid", rvalid, 0); chk("mid_rst_arready", arready, 0);
    tick(1);
    chk("mid_rst_rvalid2", rvalid, 0); chk("mid_rst_arready2", arready, 0);
    aresetn = 1'b1;
    chk("mid_rel_arready_pre", arready, 0);
    tick(1);
    chk("mid_rel_arready", arready, 1);
    rready = 1'b1;
    seen = 0;
    repeat (5) begin
      if (rvalid) seen++;
      tick(1);
    end
    chk("mid_no_stale", seen, 0);
    exp_r.push_back('{id: 4'd9, data: 32'h301, resp: 2'b00, last: 1'b1});
    ar_send(4'd9, 32'hC4, 8'd0, 2'b01);
    drain("mid_mem_intact");

    tick(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
